// File: rtl/td4_pkg.sv
// Shared constants and state types for the TD4 program loader.
// The optional checksum stage is enabled by defining TD4_LOADER_CHECKSUM_EN.
package td4_pkg;

  localparam int PROG_DEPTH = 16;
  localparam int PROG_AW    = 4;
  localparam int INSTR_W    = 8;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_CHECK,
    LD_ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Running image checksum: plain 8-bit add, wrapping mod 256.
  function automatic logic [INSTR_W-1:0] sum_add(input logic [INSTR_W-1:0] a,
                                                 input logic [INSTR_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/td4_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, start-bit glitch rejection,
// mid-bit sampling every CLK_DIV cycles, registered byte/framing-error pulses.
module td4_uart_rx
  import td4_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output rx_state_t  state
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_d       <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_d       <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          // Only a high-to-low edge starts a frame, so a line stuck low
          // after a bad stop bit does not retrigger endlessly.
          if (rx_d && !rx_s2) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s2) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/td4_prog_loader.sv
// Serial program loader: receives HEADER + 16 instruction bytes (+ checksum when
// TD4_LOADER_CHECKSUM_EN is defined) and writes them into TD4 program memory.
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int         CLK_DIV = 434,
  parameter logic [7:0] HEADER  = DEFAULT_HEADER
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rx,
  output logic               mem_we,
  output logic [PROG_AW-1:0] mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               load_ok,
  output logic               load_err,
  output loader_state_t      state,
  output rx_state_t          rx_state
);

  localparam logic [PROG_AW-1:0] LAST_ADDR = PROG_AW'(PROG_DEPTH - 1);

  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               frame_err;
  logic [PROG_AW-1:0] count;
  logic [INSTR_W-1:0] sum;

  td4_uart_rx #(
    .CLK_DIV (CLK_DIV)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err),
    .state      (rx_state)
  );

  // Handshake: byte_valid and frame_err are single-cycle pulses from the
  // receiver with no back-pressure; every pulse is consumed the cycle it
  // appears. mem_we is a one-cycle strobe qualifying mem_addr/mem_wdata.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= LD_IDLE;
      count     <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      load_ok   <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      load_ok <= 1'b0;
      case (state)
        LD_IDLE, LD_ERROR: begin
          if (byte_valid && byte_data == HEADER) begin
            state    <= LD_LOAD;
            count    <= '0;
            sum      <= '0;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
            load_err <= 1'b0;
          end
        end
        LD_LOAD: begin
          if (frame_err) begin
            state    <= LD_ERROR;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            load_err <= 1'b1;
          end else if (byte_valid) begin
            // HEADER here is ordinary data, never a restart.
            mem_we    <= 1'b1;
            mem_addr  <= count;
            mem_wdata <= byte_data;
            sum       <= sum_add(sum, byte_data);
            count     <= count + 1'b1;
            if (count == LAST_ADDR) begin
`ifdef TD4_LOADER_CHECKSUM_EN
              state <= LD_CHECK;
`else
              state    <= LD_IDLE;
              load_ok  <= 1'b1;
              cpu_hold <= 1'b0;
              busy     <= 1'b0;
`endif
            end
          end
        end
`ifdef TD4_LOADER_CHECKSUM_EN
        LD_CHECK: begin
          if (frame_err) begin
            state    <= LD_ERROR;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            load_err <= 1'b1;
          end else if (byte_valid) begin
            busy <= 1'b0;
            if (byte_data == sum) begin
              state    <= LD_IDLE;
              load_ok  <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= LD_ERROR;
              cpu_hold <= 1'b1;
              load_err <= 1'b1;
            end
          end
        end
`endif
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for td4_prog_loader: table of per-byte vectors plus
// hand-written glitch, framing-error and mid-transfer reset sequences.
module tb_td4_prog_loader;
  import td4_pkg::*;

  localparam int         DIV = 16;
  localparam logic [7:0] HDR = 8'hA5;

  logic          clock;
  logic          reset;
  logic          rx;
  logic          mem_we;
  logic [3:0]    mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          load_ok;
  logic          load_err;
  loader_state_t state;
  rx_state_t     rx_state;

  td4_prog_loader #(
    .CLK_DIV (DIV),
    .HEADER  (HDR)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .load_ok   (load_ok),
    .load_err  (load_err),
    .state     (state),
    .rx_state  (rx_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    logic       we;
    logic [3:0] addr;
    logic       ok;
    logic       hold;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ok_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every write must match the head of exp_q
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h/%0h required=none", mem_addr, mem_wdata);
        end else begin
          chk("mem_write", {20'd0, mem_addr, mem_wdata}, {20'd0, exp_q.pop_front()});
        end
      end
      if (load_ok) begin
        ok_cnt++;
        chk("hold_at_ok", {31'd0, cpu_hold}, 32'd0);
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clock);
    rx = 1'b0;
    repeat (DIV) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clock);
    end
    rx = stop;
    repeat (DIV) @(negedge clock);
    rx = 1'b1;
    repeat (DIV) @(negedge clock);
  endtask

  function automatic vec_t mk(input logic [7:0] b, input logic we, input logic [3:0] addr,
                              input logic ok, input logic hold, input logic bsy,
                              input logic err);
    vec_t v;
    v.b = b; v.we = we; v.addr = addr; v.ok = ok;
    v.hold = hold; v.busy = bsy; v.err = err;
    return v;
  endfunction

  task automatic apply_row(input vec_t v, input logic stop);
    if (v.we) exp_q.push_back({v.addr, v.b});
    ok_cnt = 0;
    send_byte(v.b, stop);
    #1;
    chk("writes_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    chk("load_ok_count", ok_cnt, {31'd0, v.ok});
    chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, v.hold});
    chk("busy", {31'd0, busy}, {31'd0, v.busy});
    chk("load_err", {31'd0, load_err}, {31'd0, v.err});
  endtask

  task automatic add_image(input logic [7:0] base, input logic [7:0] cks, input logic good);
    vecs.push_back(mk(HDR, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < 16; i++) begin
`ifdef TD4_LOADER_CHECKSUM_EN
      vecs.push_back(mk(base + 8'(i), 1'b1, 4'(i), 1'b0, 1'b1, 1'b1, 1'b0));
`else
      vecs.push_back(mk(base + 8'(i), 1'b1, 4'(i), i == 15, i != 15, i != 15, 1'b0));
`endif
    end
`ifdef TD4_LOADER_CHECKSUM_EN
    vecs.push_back(mk(cks, 1'b0, 4'd0, good, !good, 1'b0, !good));
`else
    if (cks != 8'h00 && !good) vecs.push_back(mk(cks, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {28'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_load_ok"}, {31'd0, load_ok}, 32'd0);
    chk({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
    chk({tag, "_state"}, {30'd0, state}, {30'd0, LD_IDLE});
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check_reset_vals("reset");
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // table: idle noise, good image, then bad/recovery (or trailing byte)
    vecs.push_back(mk(8'h3C, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(8'hFF, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    add_image(8'h00, 8'h78, 1'b1);
`ifdef TD4_LOADER_CHECKSUM_EN
    add_image(8'h00, 8'h00, 1'b0);
    vecs.push_back(mk(8'h3C, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1));
    add_image(8'hA0, 8'h78, 1'b1);
`else
    vecs.push_back(mk(8'h78, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    add_image(8'hA0, 8'h00, 1'b1);
`endif
    foreach (vecs[i]) apply_row(vecs[i], 1'b1);

    // glitch during LOAD, then a frame with a bad stop bit
    apply_row(mk(HDR, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0), 1'b1);
    for (int i = 0; i < 5; i++)
      apply_row(mk(8'h30 + 8'(i), 1'b1, 4'(i), 1'b0, 1'b1, 1'b1, 1'b0), 1'b1);
    @(negedge clock);
    rx = 1'b0;
    repeat (DIV / 4) @(negedge clock);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clock);
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    apply_row(mk(8'h55, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0);
    chk("frame_err_state", {30'd0, state}, {30'd0, LD_ERROR});
    apply_row(mk(8'h3C, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1);

    // reset in the middle of a transfer, then a full image from address 0
    apply_row(mk(HDR, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0), 1'b1);
    for (int i = 0; i < 5; i++)
      apply_row(mk(8'h40 + 8'(i), 1'b1, 4'(i), 1'b0, 1'b1, 1'b1, 1'b0), 1'b1);
    @(negedge clock);
    #3 reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    vecs.delete();
    add_image(8'h00, 8'h78, 1'b1);
    foreach (vecs[i]) apply_row(vecs[i], 1'b1);

    repeat (4) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
